// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM states, port IDs and default sizing.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    PORT_PIPE = 1'b0,
    PORT_DBG  = 1'b1
  } port_e;

  localparam int unsigned DEF_MEM_BYTES = 128;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the two requesters.
// DMEM_ARB_RR_EN selects round-robin on contention; otherwise port 0 has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
`ifdef DMEM_ARB_RR_EN
  input  port_e      ptr_i,
`endif
  output logic       grant_o,
  output port_e      winner_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    grant_o  = |valid_i;
    winner_o = PORT_PIPE;
    unique case (valid_i)
      2'b10:   winner_o = PORT_DBG;
`ifdef DMEM_ARB_RR_EN
      2'b11:   winner_o = ptr_i;
`else
      2'b11:   winner_o = PORT_PIPE;
`endif
      default: winner_o = PORT_PIPE;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle registered-read data memory.
// Build option: DMEM_ARB_RR_EN enables round-robin contention handling.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_we,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,

  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_we,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  state_e            state_q, state_d;
  port_e             owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic              grant;
  port_e             winner;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_legal;
  logic              issue_go;
  logic [DATA_W-1:0] resp_data;

`ifdef DMEM_ARB_RR_EN
  port_e ptr_q, ptr_d;
`endif

  dmem_arb_pick u_pick (
    .valid_i  ({p1_valid, p0_valid}),
`ifdef DMEM_ARB_RR_EN
    .ptr_i    (ptr_q),
`endif
    .grant_o  (grant),
    .winner_o (winner)
  );

  // A new request can only be taken while no access is being issued.
  assign accept    = grant && (state_q == ST_IDLE || state_q == ST_RESP);
  assign sel_addr  = (winner == PORT_DBG) ? p1_addr  : p0_addr;
  assign sel_wdata = (winner == PORT_DBG) ? p1_wdata : p0_wdata;
  assign sel_we    = (winner == PORT_DBG) ? p1_we    : p0_we;
  // Full-width unsigned compare: addresses above the last word never wrap into range.
  assign sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_WORD);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = accept ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (accept) begin
      owner_d = winner;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      we_d    = sel_we;
      err_d   = !sel_legal;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (winner == PORT_PIPE) ? PORT_DBG : PORT_PIPE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PORT_PIPE;
    else        ptr_q <= ptr_d;
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_PIPE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign p0_ready = accept && (winner == PORT_PIPE);
  assign p1_ready = accept && (winner == PORT_DBG);

  // Rejected accesses spend their ISSUE cycle with both strobes low.
  assign issue_go       = (state_q == ST_ISSUE) && !err_q;
  assign mem_read       = issue_go && !we_q;
  assign mem_write      = issue_go && we_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

  assign resp_data     = (we_q || err_q) ? '0 : mem_read_data;
  assign p0_resp_valid = (state_q == ST_RESP) && (owner_q == PORT_PIPE);
  assign p1_resp_valid = (state_q == ST_RESP) && (owner_q == PORT_DBG);
  assign p0_rdata      = p0_resp_valid ? resp_data : '0;
  assign p1_rdata      = p1_resp_valid ? resp_data : '0;
  assign p0_err        = p0_resp_valid && err_q;
  assign p1_err        = p1_resp_valid && err_q;

endmodule
